// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one i2c_controller between NUM_REQ requesters. Winners are picked
//   round-robin, their transaction fields are latched onto the ctl_* outputs,
//   and the controller's completion (or a per-phase timeout) is reported back
//   to the owning requester as a one-cycle done_o pulse.
//
//   Ports
//     clk_i, rst_ni              clock, async active-low reset
//     req_i                      per-requester request (held until done_o)
//     address_i/rw_i             per-requester 7-bit address / direction
//     register_id_i              per-requester register pointer
//     register_value_i           per-requester write data
//     grant_o                    one-hot ownership
//     done_o/err_o/rdata_o       completion pulse, error flag, read byte
//     ctl_start_o                one-cycle start to the controller
//     ctl_address_o..value_o     latched fields of the current owner
//     ctl_busy_i/done_i/nack_i   controller status
//     ctl_rdata_i                controller read byte
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | no owner; arbitrate among pending requests
//   START      | owner latched; ctl_start_o issued on the way out
//   WAIT_BUSY  | waiting for the controller to acknowledge (busy)
//   WAIT_DONE  | controller busy; waiting for its done pulse
//   RELEASE    | done_o pulsing; grant dropped and round-robin pointer moved
module i2c_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [7*NUM_REQ-1:0] address_i,
    input  logic [NUM_REQ-1:0]   rw_i,
    input  logic [8*NUM_REQ-1:0] register_id_i,
    input  logic [8*NUM_REQ-1:0] register_value_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic                 err_o,
    output logic [7:0]           rdata_o,
    output logic                 ctl_start_o,
    output logic [6:0]           ctl_address_o,
    output logic                 ctl_rw_o,
    output logic [7:0]           ctl_register_id_o,
    output logic [7:0]           ctl_register_value_o,
    input  logic                 ctl_busy_i,
    input  logic                 ctl_done_i,
    input  logic                 ctl_nack_i,
    input  logic [7:0]           ctl_rdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_winner;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_complete;
    logic               w_timeout;

    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_err;
    logic [7:0]         r_rdata;
    logic               r_start;
    logic [6:0]         r_addr;
    logic               r_rw;
    logic [7:0]         r_reg_id;
    logic [7:0]         r_reg_val;

    logic [6:0]         w_addr_arr [NUM_REQ];
    logic [7:0]         w_id_arr   [NUM_REQ];
    logic [7:0]         w_val_arr  [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_addr_arr[k] = address_i[7*k +: 7];
            w_id_arr[k]   = register_id_i[8*k +: 8];
            w_val_arr[k]  = register_value_i[8*k +: 8];
        end
    end

    // Candidate index for search position off, starting just after last winner.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] last, input int off);
        int t;
        t = int'(last) + 1 + off;
        if (t >= NUM_REQ) t = t - NUM_REQ;
        return IDX_W'(t);
    endfunction

    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_pick_valid && req_i[rr_index(r_last, i)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = rr_index(r_last, i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE:      if (w_pick_valid) w_state_next = S_START;
            S_START:     w_state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                // A done that arrives before busy is ever seen still completes.
                if (ctl_done_i)            w_complete   = 1'b1;
                else if (ctl_busy_i)       w_state_next = S_WAIT_DONE;
                else if (r_cnt == TC_LAST) w_timeout    = 1'b1;
            end
            S_WAIT_DONE: begin
                if (ctl_done_i)            w_complete = 1'b1;
                else if (r_cnt == TC_LAST) w_timeout  = 1'b1;
            end
            S_RELEASE:   w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
        if (w_complete || w_timeout) w_state_next = S_RELEASE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_winner  <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_start   <= 1'b0;
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_reg_id  <= '0;
            r_reg_val <= '0;
        end else begin
            r_start <= (r_state == S_START);
            r_done  <= '0;

            if (r_state == S_IDLE && w_pick_valid) begin
                r_grant   <= ONE_HOT << w_pick_idx;
                r_winner  <= w_pick_idx;
                r_addr    <= w_addr_arr[w_pick_idx];
                r_rw      <= rw_i[w_pick_idx];
                r_reg_id  <= w_id_arr[w_pick_idx];
                r_reg_val <= w_val_arr[w_pick_idx];
            end

            // Phase timer restarts on every state change, so each wait phase
            // gets the full budget.
            if (w_state_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE)
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_complete || w_timeout) begin
                r_done <= ONE_HOT << r_winner;
                r_err  <= w_timeout ? 1'b1 : ctl_nack_i;
                if (w_complete) r_rdata <= ctl_rdata_i;
            end

            if (r_state == S_RELEASE) begin
                r_grant <= '0;
                r_last  <= r_winner;
            end
        end
    end

    assign grant_o              = r_grant;
    assign done_o               = r_done;
    assign err_o                = r_err;
    assign rdata_o              = r_rdata;
    assign ctl_start_o          = r_start;
    assign ctl_address_o        = r_addr;
    assign ctl_rw_o             = r_rw;
    assign ctl_register_id_o    = r_reg_id;
    assign ctl_register_value_o = r_reg_val;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: one instance with the default timeout
// served by a simple controller model, and one with TIMEOUT_CYCLES=16 whose
// controller never answers.
module tb_i2c_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  req = '0;
    logic [27:0] addr_bus = '0;
    logic [3:0]  rw = '0;
    logic [31:0] rid = '0;
    logic [31:0] rval = '0;
    logic [3:0]  grant_o, done_o;
    logic        err_o, ctl_start_o, ctl_rw_o;
    logic [7:0]  rdata_o, ctl_register_id_o, ctl_register_value_o;
    logic [6:0]  ctl_address_o;
    logic        busy = 1'b0, cdone = 1'b0, nack = 1'b0;
    logic [7:0]  crdata = '0;

    logic [3:0]  t_req = '0;
    logic [27:0] t_addr_in = '0;
    logic [3:0]  t_rw_in = '0;
    logic [31:0] t_rid_in = '0;
    logic [31:0] t_rval_in = '0;
    logic [3:0]  t_grant, t_done;
    logic        t_err, t_start, t_rw;
    logic [7:0]  t_rdata, t_rid, t_rval;
    logic [6:0]  t_addr;
    logic        t_busy = 1'b0, t_cdone = 1'b0, t_nack = 1'b0;
    logic [7:0]  t_crdata = '0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int inv_bad = 0;
    int busy_len = 20;
    logic m_nack = 1'b0;
    logic [7:0] m_rdata = '0;
    logic abort = 1'b0;

    i2c_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .address_i(addr_bus), .rw_i(rw),
        .register_id_i(rid), .register_value_i(rval), .grant_o(grant_o), .done_o(done_o),
        .err_o(err_o), .rdata_o(rdata_o), .ctl_start_o(ctl_start_o),
        .ctl_address_o(ctl_address_o), .ctl_rw_o(ctl_rw_o),
        .ctl_register_id_o(ctl_register_id_o), .ctl_register_value_o(ctl_register_value_o),
        .ctl_busy_i(busy), .ctl_done_i(cdone), .ctl_nack_i(nack), .ctl_rdata_i(crdata)
    );

    i2c_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .req_i(t_req), .address_i(t_addr_in), .rw_i(t_rw_in),
        .register_id_i(t_rid_in), .register_value_i(t_rval_in), .grant_o(t_grant), .done_o(t_done),
        .err_o(t_err), .rdata_o(t_rdata), .ctl_start_o(t_start),
        .ctl_address_o(t_addr), .ctl_rw_o(t_rw),
        .ctl_register_id_o(t_rid), .ctl_register_value_o(t_rval),
        .ctl_busy_i(t_busy), .ctl_done_i(t_cdone), .ctl_nack_i(t_nack), .ctl_rdata_i(t_crdata)
    );

    initial forever #5 clk = ~clk;

    // Controller model: on a start pulse, busy for busy_len cycles then a
    // one-cycle done carrying m_nack / m_rdata. abort drops it silently.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (ctl_start_o) begin
                busy = 1'b1;
                n = 0;
                while (n < busy_len && !abort) begin
                    @(negedge clk);
                    n++;
                end
                busy = 1'b0;
                if (!abort) begin
                    cdone  = 1'b1;
                    nack   = m_nack;
                    crdata = m_rdata;
                    @(negedge clk);
                    cdone  = 1'b0;
                end
            end
        end
    end

    // Start counter and structural invariants on grant/done.
    initial forever begin
        @(negedge clk);
        if (ctl_start_o) start_cnt++;
        if (rst_n) begin
            if (!$onehot0(grant_o) || !$onehot0(done_o) || ((done_o & ~grant_o) != '0))
                inv_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int k, input logic [6:0] a, input logic r,
                              input logic [7:0] id, input logic [7:0] v);
        addr_bus[7*k +: 7] = a;
        rw[k]              = r;
        rid[8*k +: 8]      = id;
        rval[8*k +: 8]     = v;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_o == '0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_o != '0), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int s0;
        int n;
        int bad;
        int rr_exp[5] = '{0, 1, 2, 3, 0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_rdata", 32'(rdata_o), 32'h0);
        check("rst_start", 32'(ctl_start_o), 32'h0);
        check("rst_addr", 32'(ctl_address_o), 32'h0);
        check("rst_regid", 32'(ctl_register_id_o), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write transaction, with mid-transaction field changes ignored
        set_fields(0, 7'h70, 1'b0, 8'hDE, 8'h4D);
        busy_len = 20;
        m_nack   = 1'b0;
        m_rdata  = 8'h00;
        s0 = start_cnt;
        req = 4'b0001;
        @(negedge clk);
        check("single_grant", 32'(grant_o), 32'h1);
        check("single_no_start_yet", 32'(ctl_start_o), 32'h0);
        @(negedge clk);
        check("single_start", 32'(ctl_start_o), 32'h1);
        check("single_addr", 32'(ctl_address_o), 32'h70);
        check("single_rw", 32'(ctl_rw_o), 32'h0);
        check("single_regid", 32'(ctl_register_id_o), 32'hDE);
        check("single_regval", 32'(ctl_register_value_o), 32'h4D);
        set_fields(0, 7'h11, 1'b1, 8'h00, 8'h00);
        @(negedge clk);
        check("hold_start_low", 32'(ctl_start_o), 32'h0);
        check("hold_addr", 32'(ctl_address_o), 32'h70);
        check("hold_rw", 32'(ctl_rw_o), 32'h0);
        check("hold_regval", 32'(ctl_register_value_o), 32'h4D);
        wait_done(100);
        check("single_done", 32'(done_o), 32'h1);
        check("single_err", 32'(err_o), 32'h0);
        check("single_starts", 32'(start_cnt - s0), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        check("single_release", 32'(grant_o), 32'h0);
        check("single_done_pulse", 32'(done_o), 32'h0);

        // Contention from a fresh reset: 0,1,2,3,0
        for (int k = 0; k < 4; k++) set_fields(k, 7'(8'h10 + k), 1'b0, 8'(k), 8'(k));
        busy_len = 3;
        do_reset();
        s0 = start_cnt;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_done(100);
            check("rr_order", 32'(grant_o), 32'd1 << rr_exp[g]);
            check("rr_addr", 32'(ctl_address_o), 32'h10 + 32'(rr_exp[g]));
            if (g < 4) @(negedge clk);
        end
        req = 4'b0000;
        @(negedge clk);
        check("rr_starts", 32'(start_cnt - s0), 32'd5);

        // Read from requester 2
        set_fields(2, 7'h52, 1'b1, 8'h0F, 8'h00);
        busy_len = 4;
        m_nack   = 1'b0;
        m_rdata  = 8'hA5;
        req = 4'b0100;
        wait_done(100);
        check("read_done", 32'(done_o), 32'h4);
        check("read_rdata", 32'(rdata_o), 32'hA5);
        check("read_err", 32'(err_o), 32'h0);
        check("read_rw", 32'(ctl_rw_o), 32'h1);
        req = 4'b0000;
        @(negedge clk);

        // NACK on requester 1, then requester 3 arbitrates normally and
        // drops its request while granted
        set_fields(1, 7'h21, 1'b0, 8'h01, 8'h02);
        m_nack  = 1'b1;
        m_rdata = 8'h3C;
        req = 4'b0010;
        wait_done(100);
        check("nack_done", 32'(done_o), 32'h2);
        check("nack_err", 32'(err_o), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        set_fields(3, 7'h33, 1'b1, 8'h03, 8'h04);
        m_nack  = 1'b0;
        m_rdata = 8'h5A;
        req = 4'b1000;
        @(negedge clk);
        check("after_nack_grant", 32'(grant_o), 32'h8);
        req = 4'b0000;
        wait_done(100);
        check("drop_done", 32'(done_o), 32'h8);
        check("drop_err", 32'(err_o), 32'h0);
        check("drop_rdata", 32'(rdata_o), 32'h5A);
        @(negedge clk);
        check("drop_release", 32'(grant_o), 32'h0);

        // Timeout instance: controller never answers
        t_req = 4'b0001;
        @(negedge clk);
        check("to_grant", 32'(t_grant), 32'h1);
        @(negedge clk);
        n = 0;
        while (t_done == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 32'(n), 32'd16);
        check("to_done", 32'(t_done), 32'h1);
        check("to_err", 32'(t_err), 32'h1);
        check("to_rdata", 32'(t_rdata), 32'h0);
        t_req = 4'b0000;
        @(negedge clk);
        check("to_release", 32'(t_grant), 32'h0);

        // Reset during WAIT_DONE; requester 3 pending afterwards wins first
        set_fields(0, 7'h40, 1'b0, 8'h01, 8'h01);
        busy_len = 30;
        req = 4'b1001;
        @(negedge clk);
        check("rstmid_grant", 32'(grant_o), 32'h1);
        repeat (5) @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_grant0", 32'(grant_o), 32'h0);
        check("rstmid_done0", 32'(done_o), 32'h0);
        check("rstmid_addr0", 32'(ctl_address_o), 32'h0);
        check("rstmid_rdata0", 32'(rdata_o), 32'h0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o != '0 || grant_o != '0) bad++;
        end
        check("rstmid_quiet", 32'(bad), 32'd0);
        busy_len = 4;
        abort = 1'b0;
        req = 4'b1000;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_first", 32'(grant_o), 32'h8);
        wait_done(100);
        check("rstmid_done", 32'(done_o), 32'h8);
        req = 4'b0000;
        @(negedge clk);

        check("invariants", 32'(inv_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters sharing one i2c_controller (range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, meaning clk_i cycles allowed per phase (start-accept, completion) before abort.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 req_i  input  NUM_REQ  per-requester transaction request; held high until matching done_o.
REQ-006 address_i  input  7*NUM_REQ  7-bit device address per requester; slice k at [7k+6:7k].
REQ-007 rw_i  input  NUM_REQ  per-requester direction, 1=read, 0=write.
REQ-008 register_id_i  input  8*NUM_REQ  register pointer per requester.
REQ-009 register_value_i  input  8*NUM_REQ  write data per requester.
REQ-010 grant_o  output  NUM_REQ  one-hot; bit k high while requester k owns the controller.
REQ-011 done_o  output  NUM_REQ  one-cycle completion pulse to owning requester.
REQ-012 err_o  output  1  valid with any done_o pulse; 1=NACK or timeout.
REQ-013 rdata_o  output  8  read data; valid with done_o when rw=1 and err_o=0.
REQ-014 ctl_start_o  output  1  one-cycle start pulse to i2c_controller.
REQ-015 ctl_address_o / ctl_rw_o / ctl_register_id_o / ctl_register_value_o  output  7/1/8/8  latched fields of granted requester.
REQ-016 ctl_busy_i  input  1  controller transaction in progress.
REQ-017 ctl_done_i  input  1  controller one-cycle completion pulse.
REQ-018 ctl_nack_i  input  1  controller NACK flag, sampled with ctl_done_i.
REQ-019 ctl_rdata_i  input  8  controller read byte, sampled with ctl_done_i.

Function
REQ-020 FSM states IDLE, START, WAIT_BUSY, WAIT_DONE, RELEASE; encoding free.
REQ-021 IDLE: any req_i high -> select winner by round-robin, assert grant_o bit, latch its fields onto ctl_* outputs, go START next cycle.
REQ-022 Round-robin: search starts at index (last_winner+1) mod NUM_REQ, ascending with wrap; last_winner resets to NUM_REQ-1 so index 0 wins first.
REQ-023 START: ctl_start_o high exactly one cycle -> WAIT_BUSY.
REQ-024 WAIT_BUSY: ctl_busy_i high -> WAIT_DONE; ctl_done_i high in same or earlier cycle -> treat as completion directly.
REQ-025 WAIT_DONE: ctl_done_i high -> capture ctl_nack_i into err_o, ctl_rdata_i into rdata_o, pulse done_o[winner] one cycle, go RELEASE.
REQ-026 Timeout: counter cleared on entering WAIT_BUSY and WAIT_DONE; reaching TIMEOUT_CYCLES-1 -> pulse done_o[winner] with err_o=1, rdata_o unchanged, go RELEASE.
REQ-027 RELEASE: deassert grant_o, update last_winner, return IDLE; minimum one idle cycle between transactions.
REQ-028 ctl_* field outputs SHALL remain constant from latch until RELEASE; requester input changes mid-transaction ignored.
REQ-029 req_i[k] dropping while granted SHALL NOT abort; transaction completes, done_o still pulses.
REQ-030 req_i still high after done_o counts as new request, served after other pending requesters (fairness).
REQ-031 grant_o SHALL be one-hot or zero at all times; done_o at most one bit high, only for granted index.
REQ-032 Latency: req_i high in IDLE -> grant_o next cycle -> ctl_start_o cycle after.

Reset
REQ-033 rst_ni low SHALL immediately force IDLE, grant_o=0, done_o=0, err_o=0, rdata_o=0, ctl_start_o=0, ctl_* fields=0, timeout counter=0, last_winner=NUM_REQ-1.
REQ-034 Reset mid-transaction SHALL drop grant without done_o pulse; first cycle after release behaves as from power-up.

Verification
REQ-035 Single: req_i=0001, addr 0x70, rw=0, reg 0xDE, val 0x4D; controller model busy 20 cycles, done, nack=0 -> grant_o=0001, one ctl_start_o, ctl_address_o=0x70, done_o=0001, err_o=0.
REQ-036 Contention: req_i=1111 held continuously -> grant order 0,1,2,3,0; exactly one ctl_start_o per grant.
REQ-037 Read: requester 2 rw=1, controller returns rdata 0xA5 nack=0 -> done_o=0100, rdata_o=0xA5, err_o=0.
REQ-038 NACK: controller done with nack=1 -> done_o pulse with err_o=1; next request arbitrates normally.
REQ-039 Timeout: controller never asserts busy, TIMEOUT_CYCLES=16 -> done_o pulse with err_o=1 16 cycles after entering WAIT_BUSY, grant released.
REQ-040 Reset mid WAIT_DONE: rst_ni low 3 cycles -> all outputs 0 asynchronously, no done_o; afterwards req_i=1000 still pending -> granted index 3 first.
